mux4_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 4:1 select mux between four requesters.
- Drives the mux's 2-bit select and a one-hot grant.
- Holds each grant until the owner signals done, drops its request, or hits a hold timeout.
- Sits in front of the 4:1 mux; its sel output wires directly to the mux select input.

---
 rtl/mux4_rr_arbiter_pkg.sv | 7 +
 rtl/mux4_rr_arbiter_rr_pick4.sv | 16 +
 rtl/mux4_rr_arbiter.sv | 72 +++++++
 tb/tb_mux4_rr_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux4_rr_arbiter_pkg.sv
// mux4_rr_arbiter_pkg: shared constants and state encoding for the round-robin mux arbiter
package mux4_rr_arbiter_pkg;
  localparam int SEL_W = 2;
  localparam int NREQ = 4;
  localparam int DEF_MAX_HOLD = 8;
  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;
endpackage

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// rr_pick4: combinational round-robin picker, first request after ptr wins
module rr_pick4
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             any
);
  assign any = |req;
  // scan from farthest offset to nearest so the nearest set bit after ptr overwrites last
  always_comb begin
    idx = ptr;
    for (int k = NREQ; k >= 1; k--) idx = req[ptr + SEL_W'(k)] ? ptr + SEL_W'(k) : idx;
  end
endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin owner selection for a shared 4:1 mux with hold timeout
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int HOLD_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  done,
  output logic [NREQ-1:0]  grant,
  output logic [SEL_W-1:0] sel,
  output logic             sel_valid,
  output logic             timeout
);
  state_t state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [SEL_W-1:0] ptr_q, ptr_d, sel_q, sel_d, idx;
  logic [NREQ-1:0] grant_q, grant_d;
  logic sel_valid_q, sel_valid_d, timeout_q, timeout_d, any, rel;
  rr_pick4 u_pick (.req(req), .ptr(ptr_q), .idx(idx), .any(any));
  assign rel = done[sel_q] | ~req[sel_q] | (hold_q == HOLD_W'(MAX_HOLD - 1));
  // next-state: grant from IDLE via picker, release from GRANT on done/req-drop/hold limit
  always_comb begin
    state_d = state_q;
    hold_d = hold_q;
    ptr_d = ptr_q;
    sel_d = sel_q;
    grant_d = grant_q;
    sel_valid_d = sel_valid_q;
    timeout_d = 1'b0;
    if (state_q == ST_IDLE) begin
      state_d = any ? ST_GRANT : ST_IDLE;
      sel_d = any ? idx : sel_q;
      grant_d = any ? NREQ'(1) << idx : '0;
      sel_valid_d = any;
      hold_d = '0;
    end else begin
      state_d = rel ? ST_IDLE : ST_GRANT;
      hold_d = rel ? '0 : hold_q + 1'b1;
      ptr_d = rel ? sel_q : ptr_q;
      grant_d = rel ? '0 : grant_q;
      sel_valid_d = ~rel;
      timeout_d = rel & ~done[sel_q] & req[sel_q];
    end
  end
  // state and registered outputs, asynchronously cleared with ptr parked on 3
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hold_q <= '0;
      ptr_q <= 2'd3;
      sel_q <= '0;
      grant_q <= '0;
      sel_valid_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      ptr_q <= ptr_d;
      sel_q <= sel_d;
      grant_q <= grant_d;
      sel_valid_q <= sel_valid_d;
      timeout_q <= timeout_d;
    end
  end
  assign grant = grant_q;
  assign sel = sel_q;
  assign sel_valid = sel_valid_q;
  assign timeout = timeout_q;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed scenario tests for the round-robin mux arbiter
module tb_mux4_rr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] done = '0;
  logic [3:0] grant;
  logic [1:0] sel;
  logic sel_valid, timeout;
  int errors = 0;
  int checks = 0;

  mux4_rr_arbiter #(.MAX_HOLD(8), .HOLD_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .grant(grant), .sel(sel), .sel_valid(sel_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic test_reset;
    #3;
    checks++;
    if ({grant, sel, sel_valid, timeout} !== 8'b0) begin
      errors++;
      $display("FAIL reset outputs got=%b exp=%b", {grant, sel, sel_valid, timeout}, 8'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({grant, sel_valid} !== 5'b0) begin
      errors++;
      $display("FAIL reset idle got=%b exp=%b", {grant, sel_valid}, 5'b0);
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    done = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single;
    req = 4'b0001;
    @(negedge clk);
    checks++;
    if ({grant, sel, sel_valid} !== 7'b0001_00_1) begin
      errors++;
      $display("FAIL single grant got=%b exp=%b", {grant, sel, sel_valid}, 7'b0001_00_1);
    end
    done = 4'b0001;
    @(negedge clk);
    checks++;
    if ({grant, sel, sel_valid, timeout} !== 8'b0000_00_0_0) begin
      errors++;
      $display("FAIL single release got=%b exp=%b", {grant, sel, sel_valid, timeout}, 8'b0);
    end
    done = '0;
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_round_robin;
    logic [3:0] order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] sels [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({grant, sel, sel_valid} !== {order[i], sels[i], 1'b1}) begin
        errors++;
        $display("FAIL rr grant%0d got=%b exp=%b", i, {grant, sel, sel_valid}, {order[i], sels[i], 1'b1});
      end
      @(negedge clk);
      checks++;
      if (grant !== order[i]) begin
        errors++;
        $display("FAIL rr hold%0d got=%b exp=%b", i, grant, order[i]);
      end
      done = order[i];
      @(negedge clk);
      checks++;
      if ({grant, sel, sel_valid} !== {4'b0000, sels[i], 1'b0}) begin
        errors++;
        $display("FAIL rr gap%0d got=%b exp=%b", i, {grant, sel, sel_valid}, {4'b0000, sels[i], 1'b0});
      end
      done = '0;
    end
    req = '0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_timeout;
    req = 4'b0100;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if ({grant, timeout} !== 5'b0100_0) begin
        errors++;
        $display("FAIL timeout hold%0d got=%b exp=%b", k, {grant, timeout}, 5'b0100_0);
      end
    end
    @(negedge clk);
    checks++;
    if ({grant, sel, sel_valid, timeout} !== 8'b0000_10_0_1) begin
      errors++;
      $display("FAIL timeout release got=%b exp=%b", {grant, sel, sel_valid, timeout}, 8'b0000_10_0_1);
    end
    @(negedge clk);
    checks++;
    if ({grant, sel_valid, timeout} !== 6'b0100_1_0) begin
      errors++;
      $display("FAIL timeout regrant got=%b exp=%b", {grant, sel_valid, timeout}, 6'b0100_1_0);
    end
    req = '0;
    @(negedge clk);
    checks++;
    if ({grant, timeout} !== 5'b0) begin
      errors++;
      $display("FAIL timeout reqdrop got=%b exp=%b", {grant, timeout}, 5'b0);
    end
    @(negedge clk);
  endtask

  task automatic test_req_drop;
    req = 4'b0010;
    @(negedge clk);
    checks++;
    if ({grant, sel} !== 6'b0010_01) begin
      errors++;
      $display("FAIL drop grant got=%b exp=%b", {grant, sel}, 6'b0010_01);
    end
    done = 4'b0100;
    @(negedge clk);
    checks++;
    if ({grant, sel_valid} !== 5'b0010_1) begin
      errors++;
      $display("FAIL drop foreign_done got=%b exp=%b", {grant, sel_valid}, 5'b0010_1);
    end
    done = '0;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0010) begin
      errors++;
      $display("FAIL drop cycle3 got=%b exp=%b", grant, 4'b0010);
    end
    req = '0;
    @(negedge clk);
    checks++;
    if ({grant, sel, sel_valid, timeout} !== 8'b0000_01_0_0) begin
      errors++;
      $display("FAIL drop release got=%b exp=%b", {grant, sel, sel_valid, timeout}, 8'b0000_01_0_0);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    req = 4'b1000;
    @(negedge clk);
    checks++;
    if ({grant, sel} !== 6'b1000_11) begin
      errors++;
      $display("FAIL areset pre got=%b exp=%b", {grant, sel}, 6'b1000_11);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({grant, sel, sel_valid, timeout} !== 8'b0) begin
      errors++;
      $display("FAIL areset immediate got=%b exp=%b", {grant, sel, sel_valid, timeout}, 8'b0);
    end
    req = 4'b1001;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({grant, sel, sel_valid} !== 7'b0001_00_1) begin
      errors++;
      $display("FAIL areset first got=%b exp=%b", {grant, sel, sel_valid}, 7'b0001_00_1);
    end
    req = '0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_done_at_limit;
    req = 4'b0010;
    for (int k = 1; k <= 8; k++) @(negedge clk);
    checks++;
    if ({grant, timeout} !== 5'b0010_0) begin
      errors++;
      $display("FAIL limit last_cycle got=%b exp=%b", {grant, timeout}, 5'b0010_0);
    end
    done = 4'b0010;
    @(negedge clk);
    checks++;
    if ({grant, sel_valid, timeout} !== 6'b0) begin
      errors++;
      $display("FAIL limit done_wins got=%b exp=%b", {grant, sel_valid, timeout}, 6'b0);
    end
    done = '0;
    req = '0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_req_drop();
    test_async_reset();
    test_done_at_limit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
